ifetch_queue: RTL

Instruction prefetch queue between the 16-bit instruction memory port and the core's 32-bit fetch port (`i_mem_pc` / `i_mem_opcode` / `i_mem_rdy`).
- Fetches sequential 16-bit words ahead of the core into a small ring buffer.
- Presents a 32-bit window starting at whatever word address the core currently drives.
- Retires words implicitly as the PC advances, and flushes on any non-sequential PC.
- Issues at most one outstanding memory request.

---
 rtl/ifetch_queue.sv | 114 +++++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - 16-bit word prefetch ring feeding a 32-bit fetch window.
// Words retire as the PC advances; any non-sequential PC flushes the ring.
module ifetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        a_rst,
  input  logic [15:0] i_mem_pc,
  output logic [31:0] i_mem_opcode,
  output logic        i_mem_rdy,
  output logic        im_req,
  output logic [15:0] im_addr,
  input  logic        im_rdy,
  input  logic [15:0] im_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [15:0]   mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   head_addr_q, head_addr_d;
  logic [15:0]   fetch_addr_q, fetch_addr_d;
  logic          discard_q, discard_d;
  logic          im_req_q, im_req_d;
  logic [15:0]   im_addr_q, im_addr_d;

  logic [15:0]   delta;
  logic [CW-1:0] delta_s;
  logic [CW:0]   need;
  logic [PW-1:0] idx0, idx1;
  logic          hit, resp, wr_en, issue;
  logic [CW-1:0] count_pop;
  logic [15:0]   fetch_next;

  always_comb begin
    delta        = i_mem_pc - head_addr_q;
    delta_s      = delta[CW-1:0];
    hit          = (delta <= 16'd2) && (delta <= 16'(count_q));
    idx0         = rd_ptr_q + delta[PW-1:0];
    idx1         = idx0 + PW'(1);
    i_mem_opcode = {mem_q[idx1], mem_q[idx0]};
    need         = {1'b0, delta_s} + (CW+1)'(2);
    i_mem_rdy    = hit && ({1'b0, count_q} >= need);

    resp  = im_req_q & im_rdy;
    // A response landing on a flush cycle belongs to the old stream.
    wr_en = resp & hit & ~discard_q;

    rd_ptr_d    = wr_ptr_q;
    head_addr_d = i_mem_pc;
    count_pop   = '0;
    fetch_next  = i_mem_pc;
    if (hit) begin
      rd_ptr_d    = rd_ptr_q + delta[PW-1:0];
      head_addr_d = head_addr_q + delta;
      count_pop   = count_q - delta_s;
      fetch_next  = fetch_addr_q;
    end

    wr_ptr_d = wr_ptr_q + PW'(wr_en);
    count_d  = count_pop + CW'(wr_en);
    issue    = (!im_req_q || im_rdy) && (count_d < CW'(DEPTH));

    discard_d = discard_q;
    if (resp)
      discard_d = 1'b0;
    else if (!hit && im_req_q)
      discard_d = 1'b1;

    im_req_d     = im_req_q;
    im_addr_d    = im_addr_q;
    fetch_addr_d = fetch_next;
    if (issue) begin
      im_req_d     = 1'b1;
      im_addr_d    = fetch_next;
      fetch_addr_d = fetch_next + 16'd1;
    end else if (resp) begin
      im_req_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (a_rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      head_addr_q  <= '0;
      fetch_addr_q <= '0;
      discard_q    <= 1'b0;
      im_req_q     <= 1'b0;
      im_addr_q    <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      head_addr_q  <= head_addr_d;
      fetch_addr_q <= fetch_addr_d;
      discard_q    <= discard_d;
      im_req_q     <= im_req_d;
      im_addr_q    <= im_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!a_rst && wr_en)
      mem_q[wr_ptr_q] <= im_data;
  end

  assign im_req  = im_req_q;
  assign im_addr = im_addr_q;

endmodule
